// File: rtl/ising_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// ising_run_ctrl_if
//   Register bus shared with the coupling-weight matrix: one write per cycle
//   while wready is high, and a read address whose data comes back registered
//   one cycle later.
//
//   wready   : write strobe
//   wr_addr  : write address, block select in [31:24], word offset in [11:2]
//   wdata    : write data
//   rd_addr  : read address, same decoding as wr_addr
//   rdata    : read data, valid the cycle after rd_addr is presented
//
//   master : software / bus bridge side
//   slave  : register block side
// ---------------------------------------------------------------------------
interface ising_run_ctrl_if;
    logic        wready;
    logic [31:0] wr_addr;
    logic [31:0] wdata;
    logic [31:0] rd_addr;
    logic [31:0] rdata;

    modport master (
        output wready,
        output wr_addr,
        output wdata,
        output rd_addr,
        input  rdata
    );

    modport slave (
        input  wready,
        input  wr_addr,
        input  wdata,
        input  rd_addr,
        output rdata
    );
endinterface

// File: rtl/ising_run_ctrl.sv
// ---------------------------------------------------------------------------
// ising_run_ctrl
//   Run controller and spin sampler for one N-spin coupled-oscillator core.
//   Software writes the phase lengths and then GO. The block holds the core in
//   reset, lets it anneal, samples the synchronized spins and latches the
//   result into readable registers. It then pulses done_irq.
//
//   Optional feature macro: MAJORITY_VOTE_EN
//     defined   : NUM_SAMPLES samples are taken and each result bit is a
//                 strict majority vote (ties give 0)
//     undefined : a single sample is taken and NUM_SAMPLES reads 0
//
//   Register map (addr[31:24] == CTRL_ADDR_MASK, word offset addr[11:2]):
//     0x000 CTRL        W  bit0 GO, bit1 ABORT (self-clearing)
//     0x004 STATUS      R  bit0 busy, bit1 done (sticky)
//     0x008 RESET_CYC   RW
//     0x00C RUN_CYC     RW
//     0x010 NUM_SAMPLES RW (vote build only)
//     0x014 SAMPLE_GAP  RW
//     0x018 RUN_COUNT   R  completed runs
//     0x100+4k RESULT k R  spins [32k+31:32k]
//
//   Ports:
//     clk        : system clock
//     axi_rst    : synchronous active-high reset
//     bus        : register bus (slave modport)
//     spin_in    : raw core spins, asynchronous to clk
//     ising_rstn : core reset, active-low
//     start      : core start
//     busy       : run in progress (state not IDLE)
//     done_irq   : one-cycle pulse at run completion
// ---------------------------------------------------------------------------
module ising_run_ctrl #(
    parameter int         N              = 8,
    parameter int         COUNT_W        = 24,
    parameter int         SAMPLE_W       = 4,
    parameter logic [7:0] CTRL_ADDR_MASK = 8'h02
) (
    input  logic                   clk,
    input  logic                   axi_rst,
    ising_run_ctrl_if.slave        bus,
    input  logic [N-1:0]           spin_in,
    output logic                   ising_rstn,
    output logic                   start,
    output logic                   busy,
    output logic                   done_irq
);

    localparam int WORDS = (N + 31) / 32;

    localparam logic [9:0] OFF_CTRL   = 10'h000;
    localparam logic [9:0] OFF_STATUS = 10'h001;
    localparam logic [9:0] OFF_RESET  = 10'h002;
    localparam logic [9:0] OFF_RUN    = 10'h003;
    localparam logic [9:0] OFF_NSAMP  = 10'h004;
    localparam logic [9:0] OFF_GAP    = 10'h005;
    localparam logic [9:0] OFF_COUNT  = 10'h006;
    localparam logic [9:0] OFF_RESULT = 10'h040;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t state_reg;
    state_t state_next;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       wr_sel;
    logic [9:0] wr_off;
    logic       rd_sel;
    logic [9:0] rd_off;
    logic       go_cmd;
    logic       abort_cmd;
    logic       unused_bus_bits;

    assign wr_sel = bus.wready && (bus.wr_addr[31:24] == CTRL_ADDR_MASK);
    assign wr_off = bus.wr_addr[11:2];
    assign rd_sel = (bus.rd_addr[31:24] == CTRL_ADDR_MASK);
    assign rd_off = bus.rd_addr[11:2];

    // ABORT in the same write as GO wins, so GO is only seen without ABORT.
    assign abort_cmd = wr_sel && (wr_off == OFF_CTRL) && bus.wdata[1];
    assign go_cmd    = wr_sel && (wr_off == OFF_CTRL) && bus.wdata[0] && !bus.wdata[1];

    assign unused_bus_bits = ^{bus.wr_addr[23:12], bus.wr_addr[1:0],
                               bus.rd_addr[23:12], bus.rd_addr[1:0], bus.wdata};

    // ------------------------------------------------------------------
    // Software-visible configuration
    // ------------------------------------------------------------------
    logic [COUNT_W-1:0]  reset_cyc_reg;
    logic [COUNT_W-1:0]  run_cyc_reg;
    logic [COUNT_W-1:0]  sample_gap_reg;
    logic [SAMPLE_W-1:0] samples_cfg;     // effective S for the next GO
`ifdef MAJORITY_VOTE_EN
    logic [SAMPLE_W-1:0] num_samples_reg;
    assign samples_cfg = (num_samples_reg == '0) ? SAMPLE_W'(1) : num_samples_reg;
`else
    assign samples_cfg = SAMPLE_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (axi_rst) begin
            reset_cyc_reg   <= '0;
            run_cyc_reg     <= '0;
            sample_gap_reg  <= '0;
`ifdef MAJORITY_VOTE_EN
            num_samples_reg <= '0;
`endif
        end else if (wr_sel) begin
            case (wr_off)
                OFF_RESET: reset_cyc_reg  <= bus.wdata[COUNT_W-1:0];
                OFF_RUN:   run_cyc_reg    <= bus.wdata[COUNT_W-1:0];
                OFF_GAP:   sample_gap_reg <= bus.wdata[COUNT_W-1:0];
`ifdef MAJORITY_VOTE_EN
                OFF_NSAMP: num_samples_reg <= bus.wdata[SAMPLE_W-1:0];
`endif
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Spin synchronizer (2 flops)
    // ------------------------------------------------------------------
    logic [N-1:0] spin_meta_reg;
    logic [N-1:0] spin_sync_reg;

    always_ff @(posedge clk) begin
        if (axi_rst) begin
            spin_meta_reg <= '0;
            spin_sync_reg <= '0;
        end else begin
            spin_meta_reg <= spin_in;
            spin_sync_reg <= spin_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Phase sequencing
    // ------------------------------------------------------------------
    // Configuration is snapshotted at GO so that writes during a run only
    // affect the next one; each phase counter loads on entry and counts
    // down to zero (a zero length is treated as one cycle).
    logic [COUNT_W-1:0]  phase_cnt_reg;
    logic [COUNT_W-1:0]  run_len_reg;
    logic [COUNT_W-1:0]  gap_len_reg;
    logic [SAMPLE_W-1:0] samples_reg;
    logic [SAMPLE_W-1:0] samp_left_reg;
    logic                take_sample;
    logic                last_sample;
    logic                sample_entry;

    function automatic logic [COUNT_W-1:0] len_to_cnt(input logic [COUNT_W-1:0] v);
        return (v == '0) ? '0 : v - COUNT_W'(1);
    endfunction

    assign take_sample  = (state_reg == ST_SAMPLE) && (phase_cnt_reg == '0);
    assign last_sample  = take_sample && (samp_left_reg == SAMPLE_W'(1));
    assign sample_entry = (state_reg == ST_RUN) && (state_next == ST_SAMPLE);

    always_ff @(posedge clk) begin
        if (axi_rst) begin
            phase_cnt_reg <= '0;
            run_len_reg   <= '0;
            gap_len_reg   <= '0;
            samples_reg   <= '0;
            samp_left_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (go_cmd) begin
                        phase_cnt_reg <= len_to_cnt(reset_cyc_reg);
                        run_len_reg   <= len_to_cnt(run_cyc_reg);
                        gap_len_reg   <= sample_gap_reg;
                        samples_reg   <= samples_cfg;
                    end
                end
                ST_RESET: begin
                    phase_cnt_reg <= (phase_cnt_reg == '0) ? run_len_reg
                                                           : phase_cnt_reg - COUNT_W'(1);
                end
                ST_RUN: begin
                    if (phase_cnt_reg == '0) begin
                        // First sample lands on the first SAMPLE cycle.
                        samp_left_reg <= samples_reg;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg - COUNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (phase_cnt_reg != '0) begin
                        phase_cnt_reg <= phase_cnt_reg - COUNT_W'(1);
                    end else if (!last_sample) begin
                        phase_cnt_reg <= gap_len_reg;
                        samp_left_reg <= samp_left_reg - SAMPLE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (axi_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (go_cmd) state_next = ST_RESET;
            end
            ST_RESET: begin
                if (abort_cmd)                 state_next = ST_IDLE;
                else if (phase_cnt_reg == '0)  state_next = ST_RUN;
            end
            ST_RUN: begin
                if (abort_cmd)                 state_next = ST_IDLE;
                else if (phase_cnt_reg == '0)  state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort_cmd)                 state_next = ST_IDLE;
                else if (last_sample)          state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // The core keeps running through DONE; only IDLE and RESET hold it.
    always_comb begin
        ising_rstn = 1'b0;
        start      = 1'b0;
        busy       = 1'b0;
        done_irq   = 1'b0;
        case (state_reg)
            ST_RUN, ST_SAMPLE: begin
                ising_rstn = 1'b1;
                start      = 1'b1;
                busy       = 1'b1;
            end
            ST_DONE: begin
                ising_rstn = 1'b1;
                start      = 1'b1;
                busy       = 1'b1;
                done_irq   = 1'b1;
            end
            ST_RESET: begin
                busy       = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Sample accumulation
    // ------------------------------------------------------------------
    logic [N-1:0] capture_bits;

`ifdef MAJORITY_VOTE_EN
    logic [N-1:0][SAMPLE_W-1:0] vote_cnt_reg;

    always_ff @(posedge clk) begin
        if (axi_rst || sample_entry) begin
            vote_cnt_reg <= '0;
        end else if (take_sample) begin
            for (int i = 0; i < N; i++) begin
                if (spin_sync_reg[i]) vote_cnt_reg[i] <= vote_cnt_reg[i] + SAMPLE_W'(1);
            end
        end
    end

    // Strict majority: 2*count > S, so ties resolve to 0.
    for (genvar gi = 0; gi < N; gi++) begin : g_vote
        assign capture_bits[gi] = ({vote_cnt_reg[gi], 1'b0} > {1'b0, samples_reg});
    end
`else
    logic [N-1:0] sample_reg;
    logic         unused_sample_entry;

    assign unused_sample_entry = sample_entry;

    always_ff @(posedge clk) begin
        if (axi_rst) begin
            sample_reg <= '0;
        end else if (take_sample) begin
            sample_reg <= spin_sync_reg;
        end
    end

    assign capture_bits = sample_reg;
`endif

    // ------------------------------------------------------------------
    // Completion: results, sticky done, run counter
    // ------------------------------------------------------------------
    logic [N-1:0]  result_reg;
    logic          done_reg;
    logic [31:0]   run_count_reg;

    // DONE always completes once entered; ABORT only matters before it.
    always_ff @(posedge clk) begin
        if (axi_rst) begin
            result_reg    <= '0;
            done_reg      <= 1'b0;
            run_count_reg <= '0;
        end else if (state_reg == ST_DONE) begin
            result_reg    <= capture_bits;
            done_reg      <= 1'b1;
            run_count_reg <= run_count_reg + 32'd1;
        end else if ((state_reg == ST_IDLE) && go_cmd) begin
            done_reg      <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read path (registered)
    // ------------------------------------------------------------------
    logic [WORDS*32-1:0] result_pad;
    logic [31:0]         result_words [WORDS];
    logic [31:0]         rdata_next;
    logic [31:0]         rdata_reg;

    assign result_pad = (WORDS*32)'(result_reg);

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
        assign result_words[gi] = result_pad[gi*32 +: 32];
    end

    always_comb begin
        rdata_next = '0;
        if (rd_sel) begin
            case (rd_off)
                OFF_STATUS: rdata_next = {30'd0, done_reg, busy};
                OFF_RESET:  rdata_next = 32'(reset_cyc_reg);
                OFF_RUN:    rdata_next = 32'(run_cyc_reg);
`ifdef MAJORITY_VOTE_EN
                OFF_NSAMP:  rdata_next = 32'(num_samples_reg);
`endif
                OFF_GAP:    rdata_next = 32'(sample_gap_reg);
                OFF_COUNT:  rdata_next = run_count_reg;
                default: begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (rd_off == OFF_RESULT + 10'(k)) rdata_next = result_words[k];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (axi_rst) begin
            rdata_reg <= '0;
        end else begin
            rdata_reg <= rdata_next;
        end
    end

    assign bus.rdata = rdata_reg;

endmodule

// File: tb/tb_ising_run_ctrl.sv
module tb_ising_run_ctrl;

    localparam int N = 8;
    localparam logic [31:0] A_CTRL   = 32'h0200_0000;
    localparam logic [31:0] A_STATUS = 32'h0200_0004;
    localparam logic [31:0] A_RESET  = 32'h0200_0008;
    localparam logic [31:0] A_RUN    = 32'h0200_000C;
    localparam logic [31:0] A_NSAMP  = 32'h0200_0010;
    localparam logic [31:0] A_GAP    = 32'h0200_0014;
    localparam logic [31:0] A_COUNT  = 32'h0200_0018;
    localparam logic [31:0] A_RES0   = 32'h0200_0100;
    localparam logic [31:0] A_RES1   = 32'h0200_0104;

`ifdef MAJORITY_VOTE_EN
    localparam bit VOTE = 1'b1;
`else
    localparam bit VOTE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         axi_rst = 1'b1;
    logic [N-1:0] spin_in = '0;
    logic         ising_rstn;
    logic         start;
    logic         busy;
    logic         done_irq;

    ising_run_ctrl_if bus_if ();

    ising_run_ctrl #(
        .N(N), .COUNT_W(24), .SAMPLE_W(4), .CTRL_ADDR_MASK(8'h02)
    ) dut (
        .clk(clk),
        .axi_rst(axi_rst),
        .bus(bus_if),
        .spin_in(spin_in),
        .ising_rstn(ising_rstn),
        .start(start),
        .busy(busy),
        .done_irq(done_irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard queues ----------------
    typedef struct {
        string       name;
        logic [31:0] val;
    } rd_exp_t;

    typedef struct {
        int    at;
        int    sig;   // 0 ising_rstn, 1 start, 2 busy
        logic  val;
        string name;
    } probe_t;

    rd_exp_t rd_q[$];
    int      done_q[$];
    probe_t  probe_q[$];

    int checks = 0;
    int failures = 0;
    int go_cyc = 0;

    logic rd_req = 1'b0;
    logic rd_req_d = 1'b0;
    always @(posedge clk) rd_req_d <= rd_req;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        rd_exp_t e;
        probe_t  p;
        int      dexp;
        logic    act;
        if (rd_req_d) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL read_unexpected: rdata=%08h, no expected value queued", bus_if.rdata);
            end else begin
                e = rd_q.pop_front();
                if (bus_if.rdata !== e.val) begin
                    failures++;
                    $display("FAIL read_%s: got %08h required %08h", e.name, bus_if.rdata, e.val);
                end else begin
                    $display("ok   read_%s = %08h", e.name, bus_if.rdata);
                end
            end
        end
        if (done_irq) begin
            checks++;
            if (done_q.size() == 0) begin
                failures++;
                $display("FAIL done_irq_unexpected: pulse at cycle %0d, required none", cyc);
            end else begin
                dexp = done_q.pop_front();
                if (dexp != cyc) begin
                    failures++;
                    $display("FAIL done_irq_cycle: got cycle %0d required cycle %0d", cyc, dexp);
                end else begin
                    $display("ok   done_irq at cycle %0d", cyc);
                end
            end
        end
        while (probe_q.size() > 0 && probe_q[0].at <= cyc) begin
            p = probe_q.pop_front();
            case (p.sig)
                0:       act = ising_rstn;
                1:       act = start;
                default: act = busy;
            endcase
            checks++;
            if (p.at != cyc || act !== p.val) begin
                failures++;
                $display("FAIL %s: got %b at cycle %0d required %b at cycle %0d",
                         p.name, act, cyc, p.val, p.at);
            end else begin
                $display("ok   %s = %b at cycle %0d", p.name, act, cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_probe(input int at, input int sig, input logic val, input string name);
        probe_q.push_back('{at: at, sig: sig, val: val, name: name});
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        $display("     write %08h <= %08h", a, d);
        bus_if.wready  = 1'b1;
        bus_if.wr_addr = a;
        bus_if.wdata   = d;
        @(negedge clk);
        bus_if.wready  = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus_if.rd_addr = a;
        rd_req = 1'b1;
        rd_q.push_back('{name: name, val: exp});
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic bus_write_read(input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] exp, input string name);
        $display("     write %08h <= %08h with same-cycle read", a, d);
        bus_if.wready  = 1'b1;
        bus_if.wr_addr = a;
        bus_if.wdata   = d;
        bus_if.rd_addr = a;
        rd_req = 1'b1;
        rd_q.push_back('{name: name, val: exp});
        @(negedge clk);
        bus_if.wready = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic set_cfg(input int rc, input int uc, input int ns, input int gap);
        bus_write(A_RESET, 32'(rc));
        bus_write(A_RUN,   32'(uc));
        bus_write(A_NSAMP, 32'(ns));
        bus_write(A_GAP,   32'(gap));
    endtask

    // Issues GO and queues the expected phase profile and done_irq cycle.
    task automatic run_go(input int rc, input int uc, input int ns, input int gap,
                          input bit expect_done);
        int r;
        int u;
        int s;
        int total;
        r = (rc == 0) ? 1 : rc;
        u = (uc == 0) ? 1 : uc;
        s = VOTE ? ((ns == 0) ? 1 : ns) : 1;
        total = r + u + 1 + (s - 1) * (gap + 1) + 1;
        go_cyc = cyc;
        push_probe(go_cyc + 1, 2, 1'b1, "busy_after_go");
        for (int m = 1; m <= r; m++) begin
            push_probe(go_cyc + m, 0, 1'b0, "rstn_in_reset");
            push_probe(go_cyc + m, 1, 1'b0, "start_in_reset");
        end
        push_probe(go_cyc + r + 1, 0, 1'b1, "rstn_in_run");
        push_probe(go_cyc + r + 1, 1, 1'b1, "start_in_run");
        if (expect_done) begin
            done_q.push_back(go_cyc + total);
            push_probe(go_cyc + total,     2, 1'b1, "busy_in_done");
            push_probe(go_cyc + total + 1, 2, 1'b0, "busy_after_done");
        end
        bus_write(A_CTRL, 32'h1);
    endtask

    // Three sample points at cycles 5, 8, 11 after GO (R=1, U=3, G=2);
    // pins change two cycles ahead to cover the synchronizer.
    task automatic vote_run(input int ns, input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] exp_vote,
                            input logic [7:0] exp_plain, input int runs);
        set_cfg(1, 3, ns, 2);
        run_go(1, 3, ns, 2, 1'b1);
        wait_until(go_cyc + 3);  spin_in = p0;
        wait_until(go_cyc + 6);  spin_in = p1;
        wait_until(go_cyc + 9);  spin_in = p2;
        wait_until(go_cyc + 16);
        bus_read(A_RES0, VOTE ? {24'd0, exp_vote} : {24'd0, exp_plain}, "vote_result");
        bus_read(A_COUNT, 32'(runs), "vote_run_count");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        bus_if.wready  = 1'b0;
        bus_if.wr_addr = '0;
        bus_if.wdata   = '0;
        bus_if.rd_addr = '0;

        // Reset
        axi_rst = 1'b1;
        repeat (2) @(negedge clk);
        push_probe(cyc + 1, 0, 1'b0, "reset_rstn");
        push_probe(cyc + 1, 1, 1'b0, "reset_start");
        push_probe(cyc + 1, 2, 1'b0, "reset_busy");
        axi_rst = 1'b0;
        bus_read(A_STATUS, 32'h0, "reset_status");
        bus_read(A_RES0,   32'h0, "reset_result0");
        bus_read(A_COUNT,  32'h0, "reset_run_count");

        // Basic run: R=3, U=5, S=1, done at cycle 10
        spin_in = 8'hA5;
        set_cfg(3, 5, 1, 0);
        run_go(3, 5, 1, 0, 1'b1);
        wait_until(go_cyc + 12);
        bus_read(A_RES0,   32'h0000_00A5, "basic_result0");
        bus_read(A_STATUS, 32'h2, "basic_status");
        bus_read(A_COUNT,  32'd1, "basic_run_count");
        bus_read(A_RESET,  32'd3, "basic_reset_cyc");
        bus_read(A_NSAMP,  VOTE ? 32'd1 : 32'd0, "basic_num_samples");

        // Voting: 1,0,1 on bit0 -> 1; 0,1,0 -> 0; tie with S=2 -> 0
        vote_run(3, 8'hF1, 8'h30, 8'h0D, 8'h31, 8'hF1, 2);
        vote_run(3, 8'h0E, 8'hFF, 8'h80, 8'h8E, 8'h0E, 3);
        vote_run(2, 8'hFF, 8'h0F, 8'h00, 8'h0F, 8'hFF, 4);

        // GO during RUN is ignored, timing unchanged
        spin_in = 8'h3C;
        set_cfg(3, 5, 1, 0);
        run_go(3, 5, 1, 0, 1'b1);
        wait_until(go_cyc + 5);
        bus_write(A_CTRL, 32'h1);
        wait_until(go_cyc + 13);
        bus_read(A_RES0,  32'h0000_003C, "go_in_run_result0");
        bus_read(A_COUNT, 32'd5, "go_in_run_run_count");

        // ABORT on the first SAMPLE cycle: IDLE next cycle, no irq
        spin_in = 8'hFF;
        set_cfg(1, 1, 3, 4);
        run_go(1, 1, 3, 4, 1'b0);
        k = go_cyc;
        push_probe(k + 3, 2, 1'b1, "busy_in_sample");
        push_probe(k + 4, 2, 1'b0, "busy_after_abort");
        push_probe(k + 4, 0, 1'b0, "rstn_after_abort");
        wait_until(k + 3);
        bus_write(A_CTRL, 32'h2);
        wait_until(k + 20);
        bus_read(A_RES0,   32'h0000_003C, "abort_result0");
        bus_read(A_STATUS, 32'h0, "abort_status");
        bus_read(A_COUNT,  32'd5, "abort_run_count");

        // Zero-length phases: each lasts one cycle
        spin_in = 8'h5A;
        set_cfg(0, 0, 0, 0);
        run_go(0, 0, 0, 0, 1'b1);
        wait_until(go_cyc + 7);
        bus_read(A_RES0,   32'h0000_005A, "zero_result0");
        bus_read(A_STATUS, 32'h2, "zero_status");
        bus_read(A_COUNT,  32'd6, "zero_run_count");

        // GO together with ABORT: stays IDLE
        push_probe(cyc + 1, 2, 1'b0, "busy_after_go_abort");
        push_probe(cyc + 2, 2, 1'b0, "busy_after_go_abort2");
        bus_write(A_CTRL, 32'h3);
        repeat (2) @(negedge clk);
        bus_read(A_STATUS, 32'h2, "go_abort_status");

        // Mismatched block select: no effect, reads 0
        bus_write(32'h0100_0008, 32'd7);
        push_probe(cyc + 1, 2, 1'b0, "busy_after_bad_go");
        bus_write(32'h0100_0000, 32'h1);
        bus_read(32'h0100_0008, 32'h0, "mismatch_read");
        bus_read(A_RESET, 32'h0, "mismatch_no_write");

        // Read-only, unmapped, out-of-range result word
        bus_write(A_COUNT, 32'hDEAD);
        bus_read(A_COUNT, 32'd6, "run_count_read_only");
        bus_read(32'h0200_0020, 32'h0, "unmapped_read");
        bus_read(A_RES1, 32'h0, "result1_absent");

        // Same-cycle read and write return the old value
        bus_write_read(A_GAP, 32'd9, 32'd0, "same_cycle_old");
        bus_read(A_GAP, 32'd9, "same_cycle_new");

        repeat (4) @(negedge clk);
        checks++;
        if (done_q.size() != 0 || probe_q.size() != 0 || rd_q.size() != 0) begin
            failures++;
            $display("FAIL pending_expectations: done=%0d probes=%0d reads=%0d required 0/0/0",
                     done_q.size(), probe_q.size(), rd_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
